pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; successor to the fixed IF/ID latch.
- Carries PC, instruction and a sideband field between any two pipeline stages (IF/ID, ID/EX, ...) using a valid/ready handshake.
- Supports a flush (kill) input that inserts a bubble, and an explicit NOP fill.
- Optional 2-entry skid buffer registers the backpressure path.

Parameters:
- XLEN, 32, PC width in bits.
- ILEN, 32, instruction width in bits.
- SB_W, 1, sideband width (e.g. predicted-taken, exception flags); must be >=1.
- NOP_INSTR, 32'h0000_0013, instruction value loaded on reset and flush (addi x0,x0,0), truncated or zero-extended to ILEN.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held and incoming beats.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_pc  in  XLEN  upstream PC.
- in_instr  in  ILEN  upstream instruction.
- in_sb  in  SB_W  upstream sideband.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts this cycle.
- out_pc  out  XLEN  held PC.
- out_instr  out  ILEN  held instruction.
- out_sb  out  SB_W  held sideband.
- occupancy  out  2  number of beats held (0..2).

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Priority: rst > flush > handshake.
- Reset, when rst=1 at a clock edge:
  - out_valid=0, out_pc=0, out_instr=NOP_INSTR, out_sb=0, occupancy=0.
  - Skid slot cleared to the same values; state EMPTY.
- Flush, when flush=1 at a clock edge with rst=0:
  - Identical to reset for every output and internal register.
  - An in_fire beat in the same cycle is consumed and discarded; a held beat is dropped even if out_fire.
- Latency: a beat accepted at edge N appears on out_* after edge N (1-cycle latency) when the stage was empty or draining.
- out_* stay stable while out_valid=1 and out_ready=0.
- Without the skid buffer (default), states EMPTY and FULL1:
  - in_ready = !out_valid | out_ready (combinational from out_ready).
  - EMPTY: in_fire -> FULL1, main slot <= in.
  - FULL1: in_fire -> stay, main slot <= in (simultaneous in/out transfer).
  - FULL1: out_fire only -> EMPTY; main slot payload unchanged, out_valid=0.
- occupancy = number of occupied slots.
- out_valid=0 with out_ready=1 is legal and has no effect.
- in_* are ignored unless in_fire.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Enabled: adds skid slot and state FULL2.
  - in_ready is a flop: in_ready = (state != FULL2); no combinational path from out_ready.
  - EMPTY: in_fire -> FULL1.
  - FULL1: in_fire & out_fire -> FULL1, main <= in.
  - FULL1: in_fire & !out_fire -> FULL2, skid <= in.
  - FULL1: out_fire & !in_fire -> EMPTY.
  - FULL2: out_fire -> FULL1, main <= skid, skid <= NOP fill.
  - FULL2: no in_fire possible.
  - Ordering is strictly FIFO; occupancy can reach 2.
- Disabled: single-slot behaviour above; occupancy never exceeds 1; no skid flops synthesised.

Decomposition:
- Shared package pipe_pkg:
  - RV_NOP constant (32'h0000_0013).
  - Stage-state enum EMPTY/FULL1/FULL2, 2-bit encoding 0/1/2.
  - Default XLEN/ILEN localparams.
- No sub-module: the slot registers are too small to warrant one. Handshake and state logic stay in pipe_stage_reg.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1, in_pc=0x100 -> out_valid=0, out_pc=0, out_instr=0x00000013, occupancy=0, in_ready=1.
- Streaming: out_ready=1, issue PCs 0x0,0x4,0x8 back-to-back with instrs 0xA,0xB,0xC -> each appears one cycle later, one per cycle, no gaps, occupancy=1 steady.
- Stall, default build: hold out_ready=0 after 0x4 accepted -> in_ready=0 next cycle, out_pc stays 0x4. Release -> 0x8 follows on the next cycle, none lost.
- Skid, PIPE_STAGE_SKID_EN: out_ready=0 while sending 0x10,0x14,0x18 -> 0x10 and 0x14 accepted, occupancy=2, in_ready=0. out_ready=1 -> outputs 0x10, 0x14, 0x18 in order.
- Flush with concurrent input: occupancy=2 (skid build), flush=1 with in_valid=1 pc=0x40 -> next cycle out_valid=0, occupancy=0, out_instr=0x13; 0x40 never appears.
- Reset mid-stall: FULL2 state, rst=1 with out_ready=0 -> EMPTY, all outputs at reset values. Next in_valid beat passes normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for pipeline stage registers.
//   RV_NOP          : canonical RISC-V NOP (addi x0,x0,0), used as the bubble fill
//   PIPE_XLEN/ILEN  : default PC / instruction widths
//   stage_state_e   : stage occupancy state; the encoding equals the number of
//                     beats held, so it doubles as the occupancy count
package pipe_pkg;

  localparam logic [31:0] RV_NOP    = 32'h0000_0013;
  localparam int          PIPE_XLEN = 32;
  localparam int          PIPE_ILEN = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- parametrised valid/ready pipeline stage register carrying
// PC, instruction and a sideband field between two pipeline stages.
//
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) slot. in_ready
// then decodes only the state flops, which removes the combinational
// out_ready -> in_ready path. Without the macro the stage holds a single beat.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             synchronous kill: drops held and same-cycle incoming beats
//   in_valid/in_ready upstream handshake; in_pc/in_instr/in_sb upstream payload
//   out_valid/out_ready downstream handshake; out_pc/out_instr/out_sb payload
//   occupancy         number of beats held (0..2)
//
// state    | meaning
// ST_EMPTY | no beat held, outputs show last drained (or reset) payload
// ST_FULL1 | one beat in the main slot, presented on out_*
// ST_FULL2 | main and skid slots both hold beats (skid build only)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          XLEN      = PIPE_XLEN,
  parameter int          ILEN      = PIPE_ILEN,
  parameter int          SB_W      = 1,
  parameter logic [31:0] NOP_INSTR = RV_NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ILEN-1:0] in_instr,
  input  logic [SB_W-1:0] in_sb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic [SB_W-1:0] out_sb,
  output logic [1:0]      occupancy
);

  // Cast truncates or zero-extends the 32-bit NOP to the instruction width.
  localparam logic [ILEN-1:0] NOP_FILL = ILEN'(NOP_INSTR);

  stage_state_e    r_state;
  logic [XLEN-1:0] r_main_pc;
  logic [ILEN-1:0] r_main_instr;
  logic [SB_W-1:0] r_main_sb;
`ifdef PIPE_STAGE_SKID_EN
  logic [XLEN-1:0] r_skid_pc;
  logic [ILEN-1:0] r_skid_instr;
  logic [SB_W-1:0] r_skid_sb;
`endif

  logic w_out_valid;
  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;

  assign w_out_valid = (r_state != ST_EMPTY);
`ifdef PIPE_STAGE_SKID_EN
  assign w_in_ready  = (r_state != ST_FULL2);
`else
  assign w_in_ready  = !w_out_valid || out_ready;
`endif
  assign w_in_fire   = in_valid && w_in_ready;
  assign w_out_fire  = w_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state      <= ST_EMPTY;
      r_main_pc    <= '0;
      r_main_instr <= NOP_FILL;
      r_main_sb    <= '0;
`ifdef PIPE_STAGE_SKID_EN
      r_skid_pc    <= '0;
      r_skid_instr <= NOP_FILL;
      r_skid_sb    <= '0;
`endif
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state      <= ST_FULL1;
            r_main_pc    <= in_pc;
            r_main_instr <= in_instr;
            r_main_sb    <= in_sb;
          end
        end
        ST_FULL1: begin
`ifdef PIPE_STAGE_SKID_EN
          if (w_in_fire && w_out_fire) begin
            r_main_pc    <= in_pc;
            r_main_instr <= in_instr;
            r_main_sb    <= in_sb;
          end else if (w_in_fire) begin
            r_state      <= ST_FULL2;
            r_skid_pc    <= in_pc;
            r_skid_instr <= in_instr;
            r_skid_sb    <= in_sb;
          end else if (w_out_fire) begin
            r_state      <= ST_EMPTY;
          end
`else
          // in_fire here implies out_ready, so this is a pass-through transfer.
          if (w_in_fire) begin
            r_main_pc    <= in_pc;
            r_main_instr <= in_instr;
            r_main_sb    <= in_sb;
          end else if (w_out_fire) begin
            r_state      <= ST_EMPTY;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_FULL2: begin
          if (w_out_fire) begin
            r_state      <= ST_FULL1;
            r_main_pc    <= r_skid_pc;
            r_main_instr <= r_skid_instr;
            r_main_sb    <= r_skid_sb;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_FILL;
            r_skid_sb    <= '0;
          end
        end
`endif
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_pc    = r_main_pc;
  assign out_instr = r_main_instr;
  assign out_sb    = r_main_sb;
  assign occupancy = 2'(r_state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg -- self-checking bench for pipe_stage_reg. The reference
// is a FIFO queue of beats with capacity 1 (default) or 2 (skid build); the
// value shown while empty is the last beat that drained, or the reset payload.
module tb_pipe_stage_reg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int SB_W = 2;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic [SB_W-1:0] sb;
  } beat_t;

  localparam beat_t RST_BEAT = '{pc: '0, instr: 32'h0000_0013, sb: '0};

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0] in_pc, out_pc;
  logic [ILEN-1:0] in_instr, out_instr;
  logic [SB_W-1:0] in_sb, out_sb;
  logic [1:0]      occupancy;

  int n_vec = 0;
  int n_err = 0;

  beat_t q[$];
  beat_t last_b = RST_BEAT;

  always #5 clk = ~clk;

  pipe_stage_reg #(.XLEN(XLEN), .ILEN(ILEN), .SB_W(SB_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_sb(in_sb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_sb(out_sb),
    .occupancy(occupancy)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic [1:0] sb);
    beat_t b;
    b.pc = pc; b.instr = instr; b.sb = sb;
    return b;
  endfunction

  // One cycle: drive inputs, check outputs against the queue, clock, update queue.
  task automatic step(input logic r, input logic f, input logic iv, input beat_t b,
                      input logic ordy, input bit chk, output bit acc);
    beat_t exp_b;
    logic  exp_ov, exp_ir;
    rst = r; flush = f; in_valid = iv; out_ready = ordy;
    in_pc = b.pc; in_instr = b.instr; in_sb = b.sb;
    #3;
    exp_ov = (q.size() != 0);
    exp_b  = exp_ov ? q[0] : last_b;
    exp_ir = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || ordy);
    if (chk) begin
      check_val("out_valid", 64'(out_valid), 64'(exp_ov));
      check_val("in_ready",  64'(in_ready),  64'(exp_ir));
      check_val("occupancy", 64'(occupancy), 64'(q.size()));
      check_val("out_pc",    64'(out_pc),    64'(exp_b.pc));
      check_val("out_instr", 64'(out_instr), 64'(exp_b.instr));
      check_val("out_sb",    64'(out_sb),    64'(exp_b.sb));
    end
    acc = iv && exp_ir;
    @(posedge clk);
    if (r || f) begin
      q.delete();
      last_b = RST_BEAT;
    end else begin
      if (exp_ov && ordy) last_b = q.pop_front();
      if (iv && exp_ir) q.push_back(b);
    end
    #1;
  endtask

  task automatic idle(input logic ordy, input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 0, mk(32'hDEAD, 32'hBEEF, 2'd3), ordy, 1, a);
  endtask

  // Offer beats in order, holding each until accepted, with fixed out_ready.
  task automatic send(input logic [31:0] base, input int n, input logic ordy, input int max_cyc);
    bit a;
    int k = 0;
    for (int c = 0; c < max_cyc && k < n; c++) begin
      step(0, 0, 1, mk(base + 32'(4 * k), 32'hA + 32'(k), 2'(k)), ordy, 1, a);
      if (a) k++;
    end
  endtask

  initial begin
    bit a;
    int pend;
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    in_pc = '0; in_instr = '0; in_sb = '0;
    @(posedge clk); #1;

    // Reset held two cycles with a valid beat offered.
    step(1, 0, 1, mk(32'h100, 32'h55, 2'd1), 1, 0, a);
    step(1, 0, 1, mk(32'h100, 32'h55, 2'd1), 1, 1, a);
    #2;
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_pc",    64'(out_pc),    64'd0);
    check_val("rst_instr", 64'(out_instr), 64'h13);
    check_val("rst_occ",   64'(occupancy), 64'd0);
    check_val("rst_ready", 64'(in_ready),  64'd1);
    @(negedge clk); #6;

    // Streaming with out_ready=1.
    send(32'h0, 3, 1, 10);
    idle(1, 2);

    // Stall: 0x0, 0x4 flow, then out_ready drops while 0x8 is offered.
    send(32'h0, 2, 1, 10);
    for (int i = 0; i < 3; i++) step(0, 0, 1, mk(32'h8, 32'hC, 2'd2), 0, 1, a);
    idle(1, 3);

    // Skid fill with out_ready=0, then drain in order.
    send(32'h10, 3, 0, 4);
    send(32'h18, 1, 1, 4);
    idle(1, 3);

    // Flush with concurrent input while full.
    send(32'h20, 2, 0, 3);
    step(0, 1, 1, mk(32'h40, 32'h44, 2'd1), 0, 1, a);
    idle(1, 3);

    // Reset while stalled and full, then a normal beat.
    send(32'h50, 2, 0, 3);
    step(1, 0, 0, mk(32'h0, 32'h0, 2'd0), 0, 1, a);
    send(32'h60, 1, 1, 4);
    idle(1, 2);

    // Randomised traffic with occasional flush and reset.
    pend = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      logic r, f, iv, ordy;
      r    = ($urandom_range(0, 199) == 0);
      f    = ($urandom_range(0, 39) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      step(r, f, iv, mk(32'(pend), $urandom, 2'($urandom)), ordy, 1, a);
      if (a) pend += 4;
    end
    idle(1, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
